// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit and its decoder:
// opcode map, ALU control codes, FSM state encoding and the control word.
package ctrl_pkg;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_SUBC = 4'h5;
  localparam logic [3:0] OP_ADDC = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_ANDI = 4'h8;
  localparam logic [3:0] OP_ORI  = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_LW   = 4'hB;
  localparam logic [3:0] OP_SW   = 4'hC;
  localparam logic [3:0] OP_BEQ  = 4'hD;
  localparam logic [3:0] OP_BNE  = 4'hE;

  localparam logic [2:0] ALUC_AND  = 3'b000;
  localparam logic [2:0] ALUC_OR   = 3'b001;
  localparam logic [2:0] ALUC_ADD  = 3'b010;
  localparam logic [2:0] ALUC_SUB  = 3'b011;
  localparam logic [2:0] ALUC_ADDC = 3'b100;
  localparam logic [2:0] ALUC_SUBC = 3'b101;
  localparam logic [2:0] ALUC_SLT  = 3'b110;
  localparam logic [2:0] ALUC_JMP  = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // Decoded control word; an all-zero word is a NOP.
  typedef struct packed {
    logic [2:0] aluc;
    logic       alusrcb;
    logic       reg_des;
    logic       mem_to_reg;
    logic       wr_flag;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       is_jump;
    logic       is_beq;
    logic       is_bne;
  } ctrl_word_t;

endpackage

// File: rtl/mc_ctrlunit_if.sv
// Control-unit bus: IR/flag/handshake inputs and all control strobes.
// Optional macro ILLEGAL_TRAP_EN adds the 'illegal' status line.
interface mc_ctrlunit_if #(
  parameter int unsigned OP_W   = 4,
  parameter int unsigned ALUC_W = 3
);
  logic [OP_W-1:0]   op;
  logic              zero;
  logic              instr_valid;
  logic              mem_ready;
  logic              ir_we;
  logic              pc_we;
  logic              jump;
  logic              branch;
  logic [ALUC_W-1:0] aluc;
  logic              alusrcb;
  logic              mem_re;
  logic              mem_we;
  logic              reg_we;
  logic              mem_to_reg;
  logic              reg_des;
  logic              wr_flag;
  logic              mem_err;
  logic [2:0]        state_o;
`ifdef ILLEGAL_TRAP_EN
  logic              illegal;
`endif

  // Control unit side
  modport master (
    input  op, zero, instr_valid, mem_ready,
    output ir_we, pc_we, jump, branch, aluc, alusrcb, mem_re, mem_we,
           reg_we, mem_to_reg, reg_des, wr_flag, mem_err, state_o
`ifdef ILLEGAL_TRAP_EN
    , output illegal
`endif
  );

  // Datapath / memory side
  modport slave (
    output op, zero, instr_valid, mem_ready,
    input  ir_we, pc_we, jump, branch, aluc, alusrcb, mem_re, mem_we,
           reg_we, mem_to_reg, reg_des, wr_flag, mem_err, state_o
`ifdef ILLEGAL_TRAP_EN
    , input illegal
`endif
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode -> control word decoder. Opcodes outside the
// defined map (0xF and anything wider) decode to an all-zero NOP word.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W = 4
) (
  input  logic [OP_W-1:0] op,
  output ctrl_word_t      cw
);

  // Opcode table lookup
  always_comb begin
    cw = '0;
    case (op)
      OP_W'(OP_AND):  begin cw.aluc = ALUC_AND;  cw.reg_des = 1'b1; cw.reg_write = 1'b1; end
      OP_W'(OP_OR):   begin cw.aluc = ALUC_OR;   cw.reg_des = 1'b1; cw.reg_write = 1'b1; end
      OP_W'(OP_ADD):  begin cw.aluc = ALUC_ADD;  cw.reg_des = 1'b1; cw.reg_write = 1'b1; cw.wr_flag = 1'b1; end
      OP_W'(OP_SUB):  begin cw.aluc = ALUC_SUB;  cw.reg_des = 1'b1; cw.reg_write = 1'b1; cw.wr_flag = 1'b1; end
      OP_W'(OP_SLT):  begin cw.aluc = ALUC_SLT;  cw.reg_des = 1'b1; cw.reg_write = 1'b1; end
      OP_W'(OP_SUBC): begin cw.aluc = ALUC_SUBC; cw.reg_des = 1'b1; cw.reg_write = 1'b1; cw.wr_flag = 1'b1; end
      OP_W'(OP_ADDC): begin cw.aluc = ALUC_ADDC; cw.reg_des = 1'b1; cw.reg_write = 1'b1; cw.wr_flag = 1'b1; end
      OP_W'(OP_JMP):  begin cw.aluc = ALUC_JMP;  cw.is_jump = 1'b1; end
      OP_W'(OP_ANDI): begin cw.aluc = ALUC_AND;  cw.alusrcb = 1'b1; cw.reg_write = 1'b1; end
      OP_W'(OP_ORI):  begin cw.aluc = ALUC_OR;   cw.alusrcb = 1'b1; cw.reg_write = 1'b1; end
      OP_W'(OP_ADDI): begin cw.aluc = ALUC_ADD;  cw.alusrcb = 1'b1; cw.reg_write = 1'b1; cw.wr_flag = 1'b1; end
      OP_W'(OP_LW):   begin cw.aluc = ALUC_ADD;  cw.alusrcb = 1'b1; cw.reg_write = 1'b1;
                            cw.mem_to_reg = 1'b1; cw.mem_read = 1'b1; end
      OP_W'(OP_SW):   begin cw.aluc = ALUC_ADD;  cw.alusrcb = 1'b1; cw.mem_write = 1'b1; end
      OP_W'(OP_BEQ):  begin cw.aluc = ALUC_SUB;  cw.is_beq = 1'b1; end
      OP_W'(OP_BNE):  begin cw.aluc = ALUC_SUB;  cw.is_bne = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrlunit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// instruction/data memory handshakes and a data-memory wait timeout.
// Optional macro ILLEGAL_TRAP_EN: opcode 0xF traps (sticky until rst)
// instead of executing as a NOP.
module mc_ctrlunit
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W        = 4,
  parameter int unsigned ALUC_W      = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst,
  mc_ctrlunit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state, state_d;
  logic [OP_W-1:0]  op_q;
  ctrl_word_t       cw_d, cw_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             undef_op;

  ctrl_decode #(.OP_W(OP_W)) u_decode (
    .op (bus.op),
    .cw (cw_d)
  );

  assign undef_op = (op_q > OP_W'(OP_BNE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_d;
  end

  // Latch opcode and control word once per instruction in DECODE
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
      cw_q <= '0;
    end else if (state == ST_DECODE) begin
      op_q <= bus.op;
      cw_q <= cw_d;
    end
  end

  // Count cycles spent waiting in MEM; cleared whenever MEM is left
  always_ff @(posedge clk) begin
    if (rst)                                         wait_cnt <= '0;
    else if (state == ST_MEM && state_d == ST_MEM)   wait_cnt <= wait_cnt + CNT_W'(1);
    else                                             wait_cnt <= '0;
  end

  // Next state and control strobes; reset forces every output low
  always_comb begin
    state_d        = state;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.jump       = 1'b0;
    bus.branch     = 1'b0;
    bus.aluc       = '0;
    bus.alusrcb    = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.reg_we     = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_des    = 1'b0;
    bus.wr_flag    = 1'b0;
    bus.mem_err    = 1'b0;
    bus.state_o    = state;
`ifdef ILLEGAL_TRAP_EN
    bus.illegal    = 1'b0;
`endif

    if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
      bus.aluc       = ALUC_W'(cw_q.aluc);
      bus.alusrcb    = cw_q.alusrcb;
      bus.reg_des    = cw_q.reg_des;
      bus.mem_to_reg = cw_q.mem_to_reg;
    end

    case (state)
      ST_FETCH: begin
        if (bus.instr_valid) begin
          bus.ir_we = 1'b1;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (undef_op) begin
`ifdef ILLEGAL_TRAP_EN
          state_d   = ST_TRAP;
`else
          bus.pc_we = 1'b1;
          state_d   = ST_FETCH;
`endif
        end else if (cw_q.is_jump) begin
          bus.pc_we = 1'b1;
          bus.jump  = 1'b1;
          state_d   = ST_FETCH;
        end else if (cw_q.is_beq || cw_q.is_bne) begin
          bus.pc_we  = 1'b1;
          bus.branch = cw_q.is_beq ? bus.zero : ~bus.zero;
          state_d    = ST_FETCH;
        end else if (cw_q.mem_read || cw_q.mem_write) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        bus.mem_re = cw_q.mem_read;
        bus.mem_we = cw_q.mem_write;
        // ready takes priority over a timeout hit in the same cycle
        if (bus.mem_ready) begin
          if (cw_q.mem_write) begin
            bus.pc_we = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            state_d   = ST_WB;
          end
        end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
          bus.mem_err = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_WB: begin
        bus.reg_we  = cw_q.reg_write;
        bus.pc_we   = 1'b1;
        bus.wr_flag = cw_q.wr_flag;
        state_d     = ST_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP: begin
        bus.illegal = 1'b1;
        state_d     = ST_TRAP;
      end
`endif
      default: state_d = ST_FETCH;
    endcase

    if (rst) begin
      bus.ir_we      = 1'b0;
      bus.pc_we      = 1'b0;
      bus.jump       = 1'b0;
      bus.branch     = 1'b0;
      bus.aluc       = '0;
      bus.alusrcb    = 1'b0;
      bus.mem_re     = 1'b0;
      bus.mem_we     = 1'b0;
      bus.reg_we     = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_des    = 1'b0;
      bus.wr_flag    = 1'b0;
      bus.mem_err    = 1'b0;
      bus.state_o    = '0;
`ifdef ILLEGAL_TRAP_EN
      bus.illegal    = 1'b0;
`endif
    end
  end

endmodule
